// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: synchronises the rows, strobes one column per
// window, classifies each full sweep as none/single/multi and debounces
// press and release over DEBOUNCE_SCANS identical sweeps.
// Optional macro KEYPAD_HISTORY_EN: builds an 8-digit history of accepted
// codes on digitsOut; otherwise digitsOut carries only keyCode.
module keypad_scanner #(
    parameter int unsigned SCAN_BITS      = 17,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [3:0]  keyCode,
    output logic        keyValid,
    output logic        keyHeld,
    output logic [31:0] digitsOut
);

    localparam int unsigned WIN_BITS  = SCAN_BITS - 2;
    localparam logic [3:0]  DB_TARGET = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    logic [3:0]           row_meta_q, row_sync_q;
    logic [SCAN_BITS-1:0] scan_q, scan_d;
    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [3:0]           cand_q, cand_d;
    logic [3:0]           key_code_q, key_code_d;
    logic                 key_valid_q, key_valid_d;
    logic [1:0]           acc_hits_q, acc_hits_d;
    logic [3:0]           acc_code_q, acc_code_d;

    logic [1:0] col_idx;
    logic       win_end, sweep_end;
    logic [2:0] n_low;
    logic [1:0] row_idx;
    logic [1:0] col_hits;
    logic [2:0] hit_sum;
    logic [1:0] tot;
    logic [3:0] sw_code;
    logic       accept;

    function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
        logic [3:0] k;
        case ({c, r})
            4'h0: k = 4'h1;  4'h1: k = 4'h4;  4'h2: k = 4'h7;  4'h3: k = 4'h0;
            4'h4: k = 4'h2;  4'h5: k = 4'h5;  4'h6: k = 4'h8;  4'h7: k = 4'hF;
            4'h8: k = 4'h3;  4'h9: k = 4'h6;  4'hA: k = 4'h9;  4'hB: k = 4'hE;
            default: k = {2'b10, r} + 4'hA - 4'h8;
        endcase
        return k;
    endfunction

    assign col_idx   = scan_q[SCAN_BITS-1 -: 2];
    assign col       = ~(4'b0001 << col_idx);
    assign win_end   = &scan_q[WIN_BITS-1:0];
    assign sweep_end = &scan_q;
    assign keyCode   = key_code_q;
    assign keyValid  = key_valid_q;
    assign keyHeld   = (state_q == PRESSED) || (state_q == RELEASE);

    // Classify the current column sample and fold it into the sweep result
    always_comb begin
        n_low   = '0;
        row_idx = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            if (!row_sync_q[r]) begin
                n_low   = n_low + 3'd1;
                row_idx = 2'(r);
            end
        end
        col_hits = (n_low >= 3'd2) ? 2'd2 : n_low[1:0];
        hit_sum  = {1'b0, acc_hits_q} + {1'b0, col_hits};
        tot      = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        sw_code  = (col_hits != 2'd0) ? key_map(col_idx, row_idx) : acc_code_q;
        scan_d   = scan_q + 1'b1;
        acc_hits_d = acc_hits_q;
        acc_code_d = acc_code_q;
        if (win_end) begin
            acc_hits_d = sweep_end ? 2'd0 : tot;
            acc_code_d = sweep_end ? 4'd0 : sw_code;
        end
    end

    // Debounce FSM, advanced only on the sweep-end clock
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        accept  = 1'b0;
        if (sweep_end) begin
            case (state_q)
                IDLE: begin
                    if (tot == 2'd1) begin
                        cand_d = sw_code;
                        cnt_d  = 4'd1;
                        if (DB_TARGET <= 4'd1) begin
                            state_d = PRESSED;
                            accept  = 1'b1;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (tot == 2'd1 && sw_code == cand_q) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_d == DB_TARGET) begin
                            state_d = PRESSED;
                            accept  = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end
                end
                PRESSED: begin
                    if (tot == 2'd0) begin
                        cnt_d   = 4'd1;
                        state_d = (DB_TARGET <= 4'd1) ? IDLE : RELEASE;
                    end
                end
                RELEASE: begin
                    if (tot == 2'd0) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_d == DB_TARGET) begin
                            state_d = IDLE;
                            cnt_d   = 4'd0;
                        end
                    end else begin
                        state_d = PRESSED;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        key_code_d  = accept ? cand_d : key_code_q;
        key_valid_d = accept;
    end

    // Row synchroniser, scan counter, sweep accumulator and FSM registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q  <= '1;
            row_sync_q  <= '1;
            scan_q      <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            acc_hits_q  <= '0;
            acc_code_q  <= '0;
        end else begin
            row_meta_q  <= row;
            row_sync_q  <= row_meta_q;
            scan_q      <= scan_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            acc_hits_q  <= acc_hits_d;
            acc_code_q  <= acc_code_d;
        end
    end

`ifdef KEYPAD_HISTORY_EN
    logic [31:0] hist_q, hist_d;

    always_comb begin
        hist_d = accept ? {hist_q[27:0], cand_d} : hist_q;
    end

    // History of the last eight accepted codes, newest in the low nibble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist_q <= '0;
        else        hist_q <= hist_d;
    end

    assign digitsOut = hist_q;
`else
    assign digitsOut = {28'b0, key_code_q};
`endif

endmodule
